// File: rtl/tinker_decode_stage.sv
// Tinker core instruction-decode stage: hold register H, decoded output register O,
// and a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module tinker_decode_stage #(
  parameter int REG_ADDR_W    = 5,
  parameter int LIT_W         = 12,
  parameter bit SCOREBOARD_EN = 1'b1,
  localparam int INSTR_W      = 5 + 3*REG_ADDR_W + LIT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_opcode,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [REG_ADDR_W-1:0] out_rs,
  output logic [REG_ADDR_W-1:0] out_rt,
  output logic [LIT_W-1:0]      out_literal,
  output logic                  out_is_immediate,
  output logic                  out_reg_write,
  output logic                  out_is_float,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush
);

  localparam int NUM_REGS = 2**REG_ADDR_W;
  localparam int RT_LSB   = LIT_W;
  localparam int RS_LSB   = LIT_W + REG_ADDR_W;
  localparam int RD_LSB   = LIT_W + 2*REG_ADDR_W;
  localparam int OP_LSB   = LIT_W + 3*REG_ADDR_W;

  // Both handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the offered data stays stable until taken.

  logic                  h_valid;
  logic [INSTR_W-1:0]    h_instr;
  logic                  o_valid;
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_eff;
  logic [NUM_REGS-1:0]   wb_mask;
  logic [NUM_REGS-1:0]   busy_next;

  logic [4:0]            h_opcode;
  logic [REG_ADDR_W-1:0] h_rd;
  logic [REG_ADDR_W-1:0] h_rs;
  logic [REG_ADDR_W-1:0] h_rt;
  logic [LIT_W-1:0]      h_literal;
  logic                  h_is_imm;
  logic                  h_reg_write;
  logic                  h_is_float;
  logic                  hazard;
  logic                  move;

  assign h_opcode  = h_instr[OP_LSB +: 5];
  assign h_rd      = h_instr[RD_LSB +: REG_ADDR_W];
  assign h_rs      = h_instr[RS_LSB +: REG_ADDR_W];
  assign h_rt      = h_instr[RT_LSB +: REG_ADDR_W];
  assign h_literal = h_instr[LIT_W-1:0];

  always_comb begin
    h_is_imm    = 1'b0;
    h_reg_write = 1'b0;
    h_is_float  = 1'b0;
    case (h_opcode)
      5'h05, 5'h07, 5'h12, 5'h19, 5'h1B: h_is_imm = 1'b1;
      default: h_is_imm = 1'b0;
    endcase
    if ((h_opcode <= 5'h07) || (h_opcode inside {[5'h10:5'h12], [5'h14:5'h1D]}))
      h_reg_write = 1'b1;
    if (h_opcode inside {[5'h14:5'h17]})
      h_is_float = 1'b1;
  end

  // A writeback arriving this cycle already hides its busy bit from the hazard check.
  always_comb begin
    wb_mask = '0;
    if (wb_valid)
      wb_mask[wb_rd] = 1'b1;
    busy_eff = busy_q & ~wb_mask;

    hazard = 1'b0;
    if (SCOREBOARD_EN)
      hazard = h_valid & (busy_eff[h_rd] | busy_eff[h_rs] | busy_eff[h_rt]);

    move     = h_valid & ~hazard & (~o_valid | out_ready);
    in_ready = ~h_valid | move;

    busy_next = busy_eff;
    if (move && h_reg_write)
      busy_next[h_rd] = 1'b1;
    if (flush || !SCOREBOARD_EN)
      busy_next = '0;
  end

  assign out_valid = o_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_valid          <= 1'b0;
      h_instr          <= '0;
      o_valid          <= 1'b0;
      busy_q           <= '0;
      out_opcode       <= '0;
      out_rd           <= '0;
      out_rs           <= '0;
      out_rt           <= '0;
      out_literal      <= '0;
      out_is_immediate <= 1'b0;
      out_reg_write    <= 1'b0;
      out_is_float     <= 1'b0;
    end else begin
      busy_q <= busy_next;
      if (flush) begin
        h_valid <= 1'b0;
        o_valid <= 1'b0;
      end else begin
        if (in_valid && in_ready) begin
          h_valid <= 1'b1;
          h_instr <= in_instr;
        end else if (move) begin
          h_valid <= 1'b0;
        end

        if (move) begin
          o_valid          <= 1'b1;
          out_opcode       <= h_opcode;
          out_rd           <= h_rd;
          out_rs           <= h_rs;
          out_rt           <= h_rt;
          out_literal      <= h_literal;
          out_is_immediate <= h_is_imm;
          out_reg_write    <= h_reg_write;
          out_is_float     <= h_is_float;
        end else if (out_ready) begin
          o_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinker_decode_stage.sv
// Bench for tinker_decode_stage: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue-based reference model of the stage.
module tb_tinker_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  out_opcode, out_rd, out_rs, out_rt;
  logic [11:0] out_literal;
  logic        out_is_immediate, out_reg_write, out_is_float;
  logic        wb_valid, flush;
  logic [4:0]  wb_rd;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [30:0] p_in_instr;
  logic [4:0]  p_out_opcode;
  logic [5:0]  p_out_rd, p_out_rs, p_out_rt;
  logic [7:0]  p_out_literal;
  logic        p_out_is_immediate, p_out_reg_write, p_out_is_float;
  logic        p_wb_valid, p_flush;
  logic [5:0]  p_wb_rd;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: instruction waiting for issue, bundle presented downstream, busy set.
  logic [31:0] hold_q[$];
  logic [63:0] exp_q[$];
  bit          busy_m[32];
  logic [4:0]  consumed_rd[$];

  always #5 clk = ~clk;

  tinker_decode_stage u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_literal(out_literal), .out_is_immediate(out_is_immediate),
    .out_reg_write(out_reg_write), .out_is_float(out_is_float),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  tinker_decode_stage #(.REG_ADDR_W(6), .LIT_W(8), .SCOREBOARD_EN(1'b0)) u_p (
    .clk(clk), .reset_n(reset_n),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_instr(p_in_instr),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_opcode(p_out_opcode), .out_rd(p_out_rd), .out_rs(p_out_rs), .out_rt(p_out_rt),
    .out_literal(p_out_literal), .out_is_immediate(p_out_is_immediate),
    .out_reg_write(p_out_reg_write), .out_is_float(p_out_is_float),
    .wb_valid(p_wb_valid), .wb_rd(p_wb_rd), .flush(p_flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] lit);
    return {op, rd, rs, rt, lit};
  endfunction

  function automatic int fld(input logic [31:0] w, input int sh);
    return int'((w >> sh) & 32'd31);
  endfunction

  function automatic bit writes(input logic [31:0] w);
    int op;
    op = fld(w, 27);
    return (op <= 7) || (op >= 16 && op <= 18) || (op >= 20 && op <= 29);
  endfunction

  function automatic logic [63:0] ref_decode(input logic [31:0] w);
    logic [31:0] op, rd, rs, rt, lit;
    logic        imm, rw, fl;
    op  = (w >> 27) & 32'd31;
    rd  = (w >> 22) & 32'd31;
    rs  = (w >> 17) & 32'd31;
    rt  = (w >> 12) & 32'd31;
    lit = w & 32'hFFF;
    imm = op inside {32'd5, 32'd7, 32'd18, 32'd25, 32'd27};
    rw  = writes(w);
    fl  = (op >= 20) && (op <= 23);
    return {29'd0, op[4:0], rd[4:0], rs[4:0], rt[4:0], lit[11:0], imm, rw, fl};
  endfunction

  function automatic logic [63:0] dut_bundle();
    return {29'd0, out_opcode, out_rd, out_rs, out_rt, out_literal,
            out_is_immediate, out_reg_write, out_is_float};
  endfunction

  function automatic bit eff_busy(input int r, input logic wv, input logic [4:0] wrd);
    return busy_m[r] && !(wv && int'(wrd) == r);
  endfunction

  function automatic logic [31:0] rand_instr();
    return enc(5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
  endfunction

  // One clock cycle: drive inputs, compare DUT with the model, then advance the model.
  task automatic step(input logic iv, input logic [31:0] instr, input logic ordy,
                      input logic wv, input logic [4:0] wrd, input logic fl,
                      output logic acc);
    logic [31:0] h;
    bit hz, mv, exp_rdy;
    @(negedge clk);
    in_valid = iv; in_instr = instr; out_ready = ordy;
    wb_valid = wv; wb_rd = wrd; flush = fl;
    #1;
    hz = 0;
    if (hold_q.size() != 0) begin
      h  = hold_q[0];
      hz = eff_busy(fld(h, 22), wv, wrd) || eff_busy(fld(h, 17), wv, wrd) ||
           eff_busy(fld(h, 12), wv, wrd);
    end
    mv      = (hold_q.size() != 0) && !hz && ((exp_q.size() == 0) || ordy);
    exp_rdy = (hold_q.size() == 0) || mv;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0)
      check("bundle", dut_bundle(), exp_q[0]);
    acc = iv && in_ready;
    if (out_valid && ordy)
      consumed_rd.push_back(out_rd);

    if (fl) begin
      hold_q.delete();
      exp_q.delete();
      foreach (busy_m[i]) busy_m[i] = 0;
    end else begin
      if (ordy && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (wv)
        busy_m[int'(wrd)] = 0;
      if (mv) begin
        h = hold_q.pop_front();
        exp_q.push_back(ref_decode(h));
        if (writes(h))
          busy_m[fld(h, 22)] = 1;
      end
      if (iv && exp_rdy)
        hold_q.push_back(instr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_fields", dut_bundle(), 64'(0));
    check("rst_p_out_valid", 64'(p_out_valid), 64'(0));
    check("rst_p_in_ready", 64'(p_in_ready), 64'(1));
    hold_q.delete();
    exp_q.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] add_i, addi_i, sub_i, add2_i, ind_i, ind2_i;
    logic [31:0] bp[4];
    logic a;
    int idx;

    reset_n = 1'b0;
    in_valid = 0; in_instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
    p_in_valid = 0; p_in_instr = '0; p_out_ready = 0; p_wb_valid = 0; p_wb_rd = '0;
    p_flush = 0;

    add_i  = enc(5'h18, 5'd1, 5'd2, 5'd3, 12'h000);
    addi_i = enc(5'h19, 5'd1, 5'd2, 5'd0, 12'h03F);
    sub_i  = enc(5'h1A, 5'd4, 5'd1, 5'd5, 12'h000);
    add2_i = enc(5'h18, 5'd1, 5'd5, 5'd6, 12'h000);
    ind_i  = enc(5'h08, 5'd9, 5'd10, 5'd11, 12'h123);
    ind2_i = enc(5'h00, 5'd6, 5'd7, 5'd8, 12'h456);

    do_reset();

    // Field decode
    step(1, add_i, 1, 0, 5'd0, 0, a);
    step(0, '0, 1, 0, 5'd0, 0, a);
    step(1, addi_i, 1, 1, 5'd1, 0, a);
    check("add_valid", 64'(out_valid), 64'(1));
    check("add_opcode", 64'(out_opcode), 64'(5'h18));
    check("add_rd", 64'(out_rd), 64'(1));
    check("add_rs", 64'(out_rs), 64'(2));
    check("add_rt", 64'(out_rt), 64'(3));
    check("add_lit", 64'(out_literal), 64'(0));
    check("add_flags", 64'({out_is_immediate, out_reg_write, out_is_float}), 64'(3'b010));
    step(0, '0, 1, 0, 5'd0, 0, a);
    step(0, '0, 1, 0, 5'd0, 0, a);
    check("addi_opcode", 64'(out_opcode), 64'(5'h19));
    check("addi_rt", 64'(out_rt), 64'(0));
    check("addi_lit", 64'(out_literal), 64'(12'h03F));
    check("addi_imm", 64'(out_is_immediate), 64'(1));
    step(0, '0, 1, 0, 5'd0, 1, a);

    // RAW stall
    step(1, add_i, 1, 0, 5'd0, 0, a);
    step(1, sub_i, 1, 0, 5'd0, 0, a);
    step(1, ind_i, 1, 0, 5'd0, 0, a);
    check("raw_in_ready_0", 64'(in_ready), 64'(0));
    step(1, ind_i, 1, 0, 5'd0, 0, a);
    check("raw_in_ready_1", 64'(in_ready), 64'(0));
    check("raw_held", 64'(out_valid), 64'(0));
    step(1, ind_i, 1, 1, 5'd1, 0, a);
    check("raw_wb_cycle", 64'(out_valid), 64'(0));
    step(0, '0, 1, 0, 5'd0, 0, a);
    check("raw_issue", 64'(out_valid), 64'(1));
    check("raw_issue_rd", 64'(out_rd), 64'(4));
    step(0, '0, 1, 0, 5'd0, 1, a);

    // Same-register writeback and issue: the set wins
    step(1, add_i, 1, 0, 5'd0, 0, a);
    step(1, add2_i, 1, 0, 5'd0, 0, a);
    step(0, '0, 1, 1, 5'd1, 0, a);
    step(1, sub_i, 1, 0, 5'd0, 0, a);
    check("same_issue_rs", 64'(out_rs), 64'(5));
    step(1, ind_i, 1, 0, 5'd0, 0, a);
    check("same_busy_stall", 64'(in_ready), 64'(0));
    step(0, '0, 1, 0, 5'd0, 0, a);
    check("same_no_issue", 64'(out_valid), 64'(0));

    // Flush with H and O valid and busy[1], busy[4] set
    step(0, '0, 1, 1, 5'd1, 0, a);
    step(1, add_i, 0, 0, 5'd0, 0, a);
    step(1, ind_i, 1, 0, 5'd0, 0, a);
    step(1, ind2_i, 0, 0, 5'd0, 1, a);
    check("flush_pre_valid", 64'(out_valid), 64'(1));
    step(0, '0, 1, 0, 5'd0, 0, a);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    step(1, sub_i, 1, 0, 5'd0, 0, a);
    step(0, '0, 1, 0, 5'd0, 0, a);
    check("flush_busy_clear", 64'(in_ready), 64'(1));
    step(0, '0, 1, 0, 5'd0, 0, a);
    check("flush_latency", 64'(out_valid), 64'(1));
    check("flush_latency_rd", 64'(out_rd), 64'(4));
    step(0, '0, 1, 0, 5'd0, 1, a);

    // Back-pressure
    foreach (bp[i]) bp[i] = enc(5'h08, 5'(10 + i), 5'(20 + i), 5'd0, 12'(i));
    consumed_rd.delete();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      step(idx < 4, (idx < 4) ? bp[idx] : 32'd0, c >= 3, 0, 5'd0, 0, a);
      if (a) idx++;
      if (c == 2) begin
        check("bp_accepted", 64'(idx), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
      end
    end
    check("bp_count", 64'(consumed_rd.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      if (i < consumed_rd.size())
        check("bp_order", 64'(consumed_rd[i]), 64'(10 + i));

    // Randomized traffic with a reset in the middle
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
           $urandom_range(0, 40) == 0, a);
    end

    // Wider-register, no-scoreboard instance
    @(negedge clk);
    p_out_ready = 1; p_in_valid = 1;
    p_in_instr = {5'h18, 6'd33, 6'd34, 6'd35, 8'hA5};
    #1 check("p_ready_0", 64'(p_in_ready), 64'(1));
    @(negedge clk);
    p_in_instr = {5'h1A, 6'd36, 6'd33, 6'd33, 8'h5A};
    #1 check("p_ready_1", 64'(p_in_ready), 64'(1));
    @(negedge clk);
    p_in_valid = 0;
    #1;
    check("p_valid_0", 64'(p_out_valid), 64'(1));
    check("p_fields_0", 64'({p_out_opcode, p_out_rd, p_out_rs, p_out_rt, p_out_literal}),
          64'({5'h18, 6'd33, 6'd34, 6'd35, 8'hA5}));
    check("p_flags_0", 64'({p_out_is_immediate, p_out_reg_write, p_out_is_float}),
          64'(3'b010));
    @(negedge clk);
    #1;
    check("p_valid_1", 64'(p_out_valid), 64'(1));
    check("p_fields_1", 64'({p_out_opcode, p_out_rd, p_out_rs, p_out_rt, p_out_literal}),
          64'({5'h1A, 6'd36, 6'd33, 6'd33, 8'h5A}));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
